irq_controller: RTL and testbench

//   Upstream interrupt controller for the multi-cycle CPU control unit. It synchronises external

---
 rtl/irq_controller.sv | 129 ++++++++++++
 tb/tb_irq_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Prioritised interrupt controller: synchronises raw sources and filters
// them through mask and edge/level mode. Runs one REQ/ack/EOI handshake at a time.
module irq_controller #(
    parameter int          N_SRC      = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0018,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0004,
    localparam int         IW         = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src,
    input  logic             INTA_irq,
    input  logic             reg_wr,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_wdata,
    output logic [31:0]      reg_rdata,
    output logic             INT_irq,
    output logic [IW-1:0]    irq_id,
    output logic [31:0]      irq_vector,
    output logic             in_service
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_n;
    logic [N_SRC-1:0] sync1, sync2, prev;
    logic [N_SRC-1:0] mask, mode, pend;
    logic [N_SRC-1:0] rise, pending, eligible, wdata_n;
    logic [N_SRC-1:0] w1c, ack_clr, mode_drop, pend_n;
    logic [IW-1:0]    winner;
    logic             inta_d, ack, take, eoi;
    logic             wr_mask, wr_pend, wr_mode;
    logic             unused_wdata;

    assign unused_wdata = ^reg_wdata;
    assign wdata_n  = reg_wdata[N_SRC-1:0];
    assign rise     = sync2 & ~prev;
    // Edge bits come from the latch, level bits follow the synchronised line.
    assign pending  = (pend & mode) | (sync2 & ~mode);
    assign eligible = pending & mask;
    assign ack      = INTA_irq & ~inta_d;
    assign take     = (state == REQ) && ack;
    assign wr_mask  = reg_wr && (reg_addr == 2'd0);
    assign wr_pend  = reg_wr && (reg_addr == 2'd1);
    assign wr_mode  = reg_wr && (reg_addr == 2'd2);
    assign eoi      = reg_wr && (reg_addr == 2'd3) && (state == SERVICE);

    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) winner = IW'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        if (take) ack_clr[winner] = mode[winner];
    end

    assign w1c       = wr_pend ? wdata_n : '0;
    assign mode_drop = wr_mode ? (mode & ~wdata_n) : '0;
    assign pend_n    = ((pend & ~w1c & ~ack_clr) | (rise & mode)) & ~mode_drop;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (eligible != '0) state_n = REQ;
            REQ: begin
                if (ack)                  state_n = SERVICE;
                else if (eligible == '0)  state_n = IDLE;
            end
            SERVICE: if (eoi) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
            mask  <= '0;
            mode  <= '1;
            pend  <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
            prev  <= sync2;
            pend  <= pend_n;
            if (wr_mask) mask <= wdata_n;
            if (wr_mode) mode <= wdata_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            inta_d     <= 1'b0;
            INT_irq    <= 1'b0;
            in_service <= 1'b0;
            irq_id     <= '0;
            irq_vector <= VEC_BASE;
        end else begin
            state      <= state_n;
            inta_d     <= INTA_irq;
            INT_irq    <= (state_n == REQ);
            in_service <= (state_n == SERVICE);
            if (take) begin
                irq_id     <= winner;
                irq_vector <= VEC_BASE + 32'(winner) * VEC_STRIDE;
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        unique case (reg_addr)
            2'd0: reg_rdata[N_SRC-1:0] = mask;
            2'd1: reg_rdata[N_SRC-1:0] = pending;
            2'd2: reg_rdata[N_SRC-1:0] = mode;
            2'd3: begin
                reg_rdata[31]  = in_service;
                reg_rdata[7:0] = 8'(irq_id);
            end
            default: reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller; a monitor scores every acknowledge
// against a queue of expected ids and vectors.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  src = '0;
    logic        INTA_irq = 1'b0;
    logic        reg_wr = 1'b0;
    logic [1:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        INT_irq;
    logic [2:0]  irq_id;
    logic [31:0] irq_vector;
    logic        in_service;

    typedef struct {
        int          id;
        logic [31:0] vec;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic svc_q = 1'b0;

    irq_controller dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .INTA_irq   (INTA_irq),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .INT_irq    (INT_irq),
        .irq_id     (irq_id),
        .irq_vector (irq_vector),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wreg(input logic [1:0] a, input logic [31:0] d);
        reg_wr = 1'b1;
        reg_addr = a;
        reg_wdata = d;
        tick();
        reg_wr = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic rd(input string n, input logic [1:0] a,
                      input logic [31:0] exp);
        reg_addr = a;
        #1;
        chk(n, reg_rdata, exp);
    endtask

    task automatic pulse(input logic [7:0] v);
        src = v;
        tick();
        src = '0;
    endtask

    task automatic expect_ack(input int id, input logic [31:0] vec);
        exp_t e;
        e.id = id;
        e.vec = vec;
        q.push_back(e);
    endtask

    task automatic do_ack();
        INTA_irq = 1'b1;
        tick();
        INTA_irq = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (in_service && !svc_q) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ack_unexpected: got id %0d expected no ack",
                         irq_id);
            end else begin
                e = q.pop_front();
                chk("ack_id", 32'(irq_id), e.id);
                chk("ack_vec", irq_vector, e.vec);
            end
        end
        svc_q = in_service;
    end

    initial begin
        tick(2);
        chk("rst_int", 32'(INT_irq), 0);
        chk("rst_vec", irq_vector, 32'h18);
        rst = 1'b0;
        tick();
        rd("rst_mask", 2'd0, 32'h0);
        rd("rst_mode", 2'd2, 32'hFF);
        rd("rst_pend", 2'd1, 32'h0);
        rd("rst_active", 2'd3, 32'h0);

        // single edge source, latency and handshake
        wreg(2'd0, 32'h01);
        wreg(2'd2, 32'h01);
        pulse(8'h01);
        chk("t1_int_k", 32'(INT_irq), 0);
        tick();
        chk("t1_int_k1", 32'(INT_irq), 0);
        tick();
        rd("t1_pend_k2", 2'd1, 32'h01);
        chk("t1_int_k2", 32'(INT_irq), 0);
        tick();
        chk("t1_int_k3", 32'(INT_irq), 1);
        expect_ack(0, 32'h18);
        do_ack();
        chk("t1_int_ack", 32'(INT_irq), 0);
        chk("t1_svc", 32'(in_service), 1);
        rd("t1_pend_ack", 2'd1, 32'h0);
        rd("t1_active", 2'd3, 32'h8000_0000);
        wreg(2'd3, 32'h0);
        chk("t1_eoi", 32'(in_service), 0);

        // simultaneous sources, priority order
        wreg(2'd0, 32'hFF);
        wreg(2'd2, 32'hFF);
        pulse(8'h24);
        tick(3);
        chk("t2_int", 32'(INT_irq), 1);
        expect_ack(2, 32'h20);
        do_ack();
        rd("t2_pend", 2'd1, 32'h20);
        rd("t2_active", 2'd3, 32'h8000_0002);
        wreg(2'd3, 32'h0);
        chk("t2_int_eoi", 32'(INT_irq), 0);
        tick();
        chk("t2_int_re", 32'(INT_irq), 1);
        expect_ack(5, 32'h2C);
        do_ack();
        wreg(2'd3, 32'h0);

        // higher priority arrives while requesting
        pulse(8'h40);
        tick(3);
        chk("t3_int", 32'(INT_irq), 1);
        pulse(8'h02);
        tick(2);
        expect_ack(1, 32'h1C);
        do_ack();
        rd("t3_pend", 2'd1, 32'h40);
        wreg(2'd3, 32'h0);
        tick();
        expect_ack(6, 32'h30);
        do_ack();
        wreg(2'd3, 32'h0);
        rd("t3_pend_end", 2'd1, 32'h0);

        // level source withdrawn before ack
        wreg(2'd2, 32'hF7);
        src = 8'h08;
        tick(3);
        chk("t4_int_lvl", 32'(INT_irq), 1);
        rd("t4_pend_lvl", 2'd1, 32'h08);
        src = '0;
        tick(3);
        chk("t4_withdraw", 32'(INT_irq), 0);
        chk("t4_idle", 32'(in_service), 0);
        rd("t4_pend0", 2'd1, 32'h0);

        // held INTA acknowledges exactly once
        pulse(8'h01);
        tick(3);
        expect_ack(0, 32'h18);
        INTA_irq = 1'b1;
        tick();
        pulse(8'h04);
        tick(8);
        wreg(2'd3, 32'h0);
        tick(2);
        chk("t4_held_svc", 32'(in_service), 0);
        chk("t4_held_int", 32'(INT_irq), 1);
        INTA_irq = 1'b0;
        tick();
        expect_ack(2, 32'h20);
        do_ack();
        wreg(2'd3, 32'h0);

        // masked pending and W1C races
        wreg(2'd2, 32'hFF);
        wreg(2'd0, 32'h00);
        pulse(8'h10);
        tick(3);
        rd("t5_pend", 2'd1, 32'h10);
        chk("t5_int", 32'(INT_irq), 0);
        wreg(2'd1, 32'h10);
        rd("t5_w1c", 2'd1, 32'h0);
        pulse(8'h10);
        tick();
        wreg(2'd1, 32'h10);
        rd("t5_setwins", 2'd1, 32'h10);
        wreg(2'd1, 32'h10);
        rd("t5_clr", 2'd1, 32'h0);

        // reset in service
        wreg(2'd0, 32'hFF);
        pulse(8'h01);
        tick(3);
        expect_ack(0, 32'h18);
        do_ack();
        wreg(2'd2, 32'h0F);
        chk("t6_pre", 32'(in_service), 1);
        rst = 1'b1;
        #1;
        chk("t6_svc", 32'(in_service), 0);
        chk("t6_int", 32'(INT_irq), 0);
        chk("t6_id", 32'(irq_id), 0);
        chk("t6_vec", irq_vector, 32'h18);
        tick();
        rst = 1'b0;
        tick();
        rd("t6_mask", 2'd0, 32'h0);
        rd("t6_pend", 2'd1, 32'h0);
        rd("t6_mode", 2'd2, 32'hFF);
        tick(4);
        chk("t6_quiet", 32'(INT_irq), 0);

        chk("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
